// File: rtl/seg_scan_mux_if.sv
// Load handshake bundle for seg_scan_mux: a producer offers a 16-bit display
// value and the scanner accepts it when it has no update already waiting.
interface seg_scan_mux_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed hex display scanner with a frame-aligned,
// double-buffered load path and optional leading-zero blanking.
module seg_scan_mux #(
    parameter int unsigned CLK_DIV       = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    seg_scan_mux_if.slave        load,
    output logic [3:0]           hex_sel,
    output logic [3:0]           an
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    digit;
    logic [15:0]   disp;
    logic [15:0]   shadow;
    logic          pending;
    logic          tick;
    logic          frame_end;
    logic          take;
    logic [3:0]    zero_above;

    assign tick            = en && (presc == PRESC_LAST);
    assign frame_end       = tick && (digit == 2'd3);
    assign take            = load.load_valid && !pending;
    assign load.load_ready = !pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= 2'd0;
        end else if (en) begin
            if (tick) begin
                presc <= '0;
                digit <= digit + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // A new value only reaches disp at a frame boundary, so a frame never
    // shows a mix of old and new nibbles. A handshake on the boundary cycle
    // itself lands in shadow and waits for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp    <= 16'h0000;
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            if (take) begin
                shadow  <= load.load_data;
                pending <= 1'b1;
            end
        end
    end

    // zero_above[k] marks digit k as part of a run of leading zeros; digit 0
    // is never blanked so a zero value still shows a single "0".
    always_comb begin
        zero_above    = 4'b0000;
        zero_above[3] = (disp[15:12] == 4'h0);
        zero_above[2] = (disp[15:8]  == 8'h00);
        zero_above[1] = (disp[15:4]  == 12'h000);
    end

    always_comb begin
        hex_sel = disp[{digit, 2'b00} +: 4];
        an      = 4'hF;
        if (en && !(BLANK_LEADING && zero_above[digit])) begin
            an = ~(4'b0001 << digit);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: two instances (blanking on and off)
// share stimulus and are checked against a frame/phase reference model.
module tb_seg_scan_mux;

    localparam int D     = 4;
    localparam int FRAME = 4 * D;

    typedef struct packed {
        logic [3:0] an_b;
        logic [3:0] an_f;
        logic [3:0] hex;
        logic       ready;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] hex_b, an_b, hex_f, an_f;

    seg_scan_mux_if lb ();
    seg_scan_mux_if lf ();

    seg_scan_mux #(.CLK_DIV(D), .BLANK_LEADING(1'b1)) u_dut_blank (
        .clk(clk), .rst_n(rst_n), .en(en), .load(lb),
        .hex_sel(hex_b), .an(an_b)
    );

    seg_scan_mux #(.CLK_DIV(D), .BLANK_LEADING(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .en(en), .load(lf),
        .hex_sel(hex_f), .an(an_f)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          phase    = 0;
    logic [15:0] m_disp   = 16'h0000;
    logic [15:0] m_shadow = 16'h0000;
    bit          m_pend   = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;

    // Reference: phase counts enabled cycles within a 4*D frame; digit = phase/D.
    function automatic logic [3:0] exp_an(input int ph, input logic [15:0] dv,
                                          input bit en_i, input bit blank);
        int          d;
        logic [15:0] upper;
        d     = ph / D;
        upper = dv >> (4 * d);
        if (!en_i) return 4'hF;
        if (blank && d != 0 && upper == 16'h0000) return 4'hF;
        return 4'(~(1 << d));
    endfunction

    task automatic applyStimulus(input bit r, input bit e, input bit v,
                                 input logic [15:0] data);
        exp_t        x;
        bit          boundary;
        bit          hs;
        logic [15:0] sh;
        @(negedge clk);
        rst_n = r;
        en    = e;
        lb.load_valid = v;
        lf.load_valid = v;
        lb.load_data  = data;
        lf.load_data  = data;
        if (!r) begin
            phase    = 0;
            m_disp   = 16'h0000;
            m_shadow = 16'h0000;
            m_pend   = 1'b0;
        end
        sh      = m_disp >> (4 * (phase / D));
        x.hex   = sh[3:0];
        x.ready = !m_pend;
        x.an_b  = exp_an(phase, m_disp, e, 1'b1);
        x.an_f  = exp_an(phase, m_disp, e, 1'b0);
        sb.push_back(x);
        if (r) begin
            boundary = e && (phase == FRAME - 1);
            hs       = v && !m_pend;
            if (boundary && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (hs) begin
                m_shadow = data;
                m_pend   = 1'b1;
            end
            if (e) phase = (phase + 1) % FRAME;
        end
    endtask

    task automatic checkOutput(input exp_t x);
        bit bad;
        bad = 1'b0;
        vectors++;
        if (an_b !== x.an_b) begin
            $display("[TB] FAIL an_blank: got %b expected %b at %0t", an_b, x.an_b, $time);
            bad = 1'b1;
        end
        if (an_f !== x.an_f) begin
            $display("[TB] FAIL an_full: got %b expected %b at %0t", an_f, x.an_f, $time);
            bad = 1'b1;
        end
        if (hex_b !== x.hex || hex_f !== x.hex) begin
            $display("[TB] FAIL hex_sel: got %h/%h expected %h at %0t", hex_b, hex_f, x.hex, $time);
            bad = 1'b1;
        end
        if (lb.load_ready !== x.ready || lf.load_ready !== x.ready) begin
            $display("[TB] FAIL load_ready: got %b/%b expected %b at %0t",
                     lb.load_ready, lf.load_ready, x.ready, $time);
            bad = 1'b1;
        end
        if (bad) miscompares++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        logic [15:0] masks [4];
        bit          r, e, v;
        int          g;
        masks[0] = 16'h000F;
        masks[1] = 16'h00FF;
        masks[2] = 16'h0FFF;
        masks[3] = 16'hFFFF;
        lb.load_valid = 1'b0;
        lf.load_valid = 1'b0;
        lb.load_data  = 16'h0000;
        lf.load_data  = 16'h0000;

        $display("[TB] reset and idle scan");
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (32) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] single loads 0A30h and 0005h");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0A30);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0005);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] back-to-back loads with load_valid held");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
        g = 0;
        while (m_pend && g < 100) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h5678);
            g++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h5678);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] handshake on the frame-boundary cycle");
        g = 0;
        while (!(phase == FRAME - 1 && !m_pend) && g < 100) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
            g++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hBEEF);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] enable dropped mid-slot on digit 2");
        g = 0;
        while (phase != 2 * D + 1 && g < 100) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
            g++;
        end
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (24) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] handshake while disabled");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h00C1);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] reset with a value pending");
        g = 0;
        while (phase != 0 && g < 100) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
            g++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h4321);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);

        $display("[TB] randomized traffic");
        repeat (3000) begin
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) == 0);
            applyStimulus(r, e, v, 16'($urandom) & masks[$urandom_range(0, 3)]);
        end

        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLANK_LEADING, default 1: 1 = blank leading zero digits, 0 = show all four digits.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 en  input  1  1 = scan runs and digits are driven; 0 = scan frozen and all anodes off.
REQ-006 load_valid  input  1  new display value offered on load_data.
REQ-007 load_data  input  16  four hex nibbles; bits [3:0] are digit 0 (rightmost).
REQ-008 load_ready  output  1  block can accept load_data this cycle.
REQ-009 hex_sel  output  4  nibble for the active digit; feeds the hex-to-seven-segment decoder selectHex input.
REQ-010 an  output  4  digit anode enables, active-low, at most one bit low.

Function
REQ-011 Prescaler counts 0..CLK_DIV-1 while en=1, holds while en=0, and wraps to 0 after CLK_DIV-1.
REQ-012 tick is asserted internally for exactly one cycle when the prescaler equals CLK_DIV-1 and en=1.
REQ-013 Digit counter advances on tick as 0->1->2->3->0.
REQ-014 hex_sel equals disp[4*d+3:4*d], where d is the digit counter and disp is the 16-bit displayed register; it is combinational from registers, with 0 cycles latency.
REQ-015 an is active-low one-hot of d: d=0 -> 1110, d=1 -> 1101, d=2 -> 1011, d=3 -> 0111.
REQ-016 an is 1111 whenever en=0, regardless of d.
REQ-017 Leading-zero blanking (BLANK_LEADING=1):
- a digit is blanked when it and every higher nibble of disp are zero;
- digit 0 is never blanked;
- a blanked slot drives an=1111 and still consumes its full slot time.
REQ-018 Load handshake: load_ready = NOT pending.
REQ-019 On a cycle with load_valid=1 and load_ready=1, shadow<=load_data and pending<=1.
REQ-020 Frame boundary is defined as tick while d=3.
REQ-021 At a frame boundary with pending=1: disp<=shadow and pending<=0; the new value is visible from digit 0 onward, so no frame ever mixes old and new nibbles.
REQ-022 At a frame boundary with pending=0, disp is unchanged.
REQ-023 Same-cycle frame boundary and handshake when pending=0: shadow captures load_data and pending becomes 1; disp is unchanged and updates at the next frame boundary.
REQ-024 Same-cycle frame boundary and handshake when pending=1: impossible, because load_ready=0.
REQ-025 load_data is ignored when the handshake does not complete; load_valid may be held high without side effects.
REQ-026 en=0 does not block the handshake: shadow may load, but disp updates only at a frame boundary, which requires en=1.

Reset
REQ-027 rst_n low forces immediately, asynchronously: prescaler=0, d=0, disp=0000h, shadow=0000h, pending=0.
REQ-028 Resulting outputs during reset: load_ready=1, hex_sel=0; an=1110 if en=1, else 1111.
REQ-029 Reset asserted mid-frame or mid-handshake discards the pending value; after release, the scan restarts at digit 0 with a full slot.

Verification (CLK_DIV=4 unless stated)
REQ-030 Reset, then en=1 for 32 cycles:
- an pattern 1110,1111,1111,1111 repeating, each held 4 cycles;
- hex_sel=0 throughout (digits 1-3 blanked, since disp=0000h).
REQ-031 BLANK_LEADING=1, load 0A30h:
- before the frame boundary, disp remains 0000h;
- from the next frame the sequence is an/hex_sel: 1110/0, 1101/3, 1011/A, 1111/0 (digit 3 blanked).
REQ-032 BLANK_LEADING=0, load 0005h: all four anodes are cycled, and hex_sel reads 5,0,0,0.
REQ-033 Back-to-back loads:
- load_valid held high with data 1234h, then 5678h;
- the first is accepted and load_ready drops;
- 5678h is accepted only in the cycle after the frame boundary where disp becomes 1234h;
- disp becomes 5678h one frame later.
REQ-034 Handshake on the exact frame-boundary cycle with pending=0, data BEEFh: disp unchanged for that frame, and BEEFh is shown starting 16 cycles later.
REQ-035 en dropped to 0 mid-slot at d=2 for 10 cycles:
- an=1111, and prescaler and d hold;
- on en=1, d=2 resumes with its remaining slot count.
- Also: rst_n pulsed low with pending=1 -> pending=0, disp=0000h, d=0.
